// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM encoding and baud constants for the tx and future rx paths.
package uart_pkg;

  localparam int unsigned CLK_FREQ_HZ          = 100_000_000;
  localparam int unsigned BAUD_115200          = 115_200;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_115200;
  localparam int unsigned DATA_BITS            = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte handshake into the UART transmitter: source is master, transmitter is slave.
interface uart_transmitter_if;

  logic [uart_pkg::DATA_BITS-1:0] tx_data;
  logic                           tx_valid;
  logic                           tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; caller must not push when full or pop when empty.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: handshake into a byte FIFO, serialized LSB first with optional parity and 1-2 stop bits.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter  int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter  int unsigned FIFO_DEPTH   = 16,
  parameter  int unsigned PARITY_EN    = 0,
  parameter  int unsigned PARITY_ODD   = 0,
  parameter  int unsigned STOP_BITS    = 1,
  localparam int unsigned CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  uart_transmitter_if.slave   bus,
  output logic                uart_tx,
  output logic                busy,
  output logic [CW-1:0]       fifo_count
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  uart_state_e          state_q, state_d;
  logic [BW-1:0]        baud_q;
  logic [2:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 fifo_full, fifo_empty;
  logic                 push_c, pop_c, line_c, baud_wrap_c;
  logic                 data_last_c, stop_last_c, busy_c;
  logic [CW-1:0]        count_next_c;

  assign bus.tx_ready = !rst && !fifo_full;
  assign push_c       = bus.tx_valid && bus.tx_ready;
  assign baud_wrap_c  = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign data_last_c  = (bit_q == 3'd7);
  assign stop_last_c  = (bit_q == 3'(STOP_BITS - 1));

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .pop     (pop_c),
    .wr_data (bus.tx_data),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!fifo_empty) state_d = ST_START;
      ST_START:  if (baud_wrap_c) state_d = ST_DATA;
      ST_DATA:   if (baud_wrap_c && data_last_c) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (baud_wrap_c) state_d = ST_STOP;
      ST_STOP:   if (baud_wrap_c && stop_last_c) state_d = fifo_empty ? ST_IDLE : ST_START;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next line level and pop strobe; the line is registered so each level lands one edge later.
  always_comb begin
    pop_c  = 1'b0;
    line_c = 1'b1;
    case (state_q)
      ST_IDLE: begin
        pop_c  = !fifo_empty;
        line_c = fifo_empty;
      end
      ST_START:  line_c = baud_wrap_c ? shift_q[0] : 1'b0;
      ST_DATA: begin
        if (!baud_wrap_c)     line_c = shift_q[0];
        else if (!data_last_c) line_c = shift_q[1];
        else                  line_c = (PARITY_EN != 0) ? parity_q : 1'b1;
      end
      ST_PARITY: line_c = baud_wrap_c ? 1'b1 : parity_q;
      ST_STOP: begin
        pop_c  = baud_wrap_c && stop_last_c && !fifo_empty;
        line_c = !pop_c;
      end
      default: line_c = 1'b1;
    endcase
  end

  assign count_next_c = fifo_count + CW'(push_c) - CW'(pop_c);
  assign busy_c       = (state_d != ST_IDLE) || (count_next_c != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      uart_tx <= line_c;
      busy    <= busy_c;
      if (pop_c || state_q == ST_IDLE || baud_wrap_c) baud_q <= '0;
      else                                            baud_q <= baud_q + BW'(1);
      // Bit index walks data bits, rolls 7->0, then counts stop bits.
      if (pop_c)
        bit_q <= '0;
      else if (baud_wrap_c && (state_q == ST_DATA || state_q == ST_STOP))
        bit_q <= bit_q + 3'd1;
      if (pop_c) begin
        shift_q  <= fifo_head;
        parity_q <= (^fifo_head) ^ 1'(PARITY_ODD);
      end else if (baud_wrap_c && state_q == ST_DATA) begin
        shift_q <= shift_q >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: base 8N1, even/odd parity, two stop bits, burst and reset cases.
module tb_uart_transmitter;

  localparam int unsigned CPB = 4;
  localparam int unsigned CW  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    line;
  logic [3:0]    busy;
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_transmitter_if bus_b ();
  uart_transmitter_if bus_pe ();
  uart_transmitter_if bus_po ();
  uart_transmitter_if bus_s2 ();

  uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b), .uart_tx(line[0]), .busy(busy[0]), .fifo_count(cnt0));
  uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_pe (
    .clk(clk), .rst(rst), .bus(bus_pe), .uart_tx(line[1]), .busy(busy[1]), .fifo_count(cnt1));
  uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_po (
    .clk(clk), .rst(rst), .bus(bus_po), .uart_tx(line[2]), .busy(busy[2]), .fifo_count(cnt2));
  uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_s2 (
    .clk(clk), .rst(rst), .bus(bus_s2), .uart_tx(line[3]), .busy(busy[3]), .fifo_count(cnt3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic ready_of(input int d);
    case (d)
      0:       return bus_b.tx_ready;
      1:       return bus_pe.tx_ready;
      2:       return bus_po.tx_ready;
      default: return bus_s2.tx_ready;
    endcase
  endfunction

  function automatic logic [CW-1:0] cnt_of(input int d);
    case (d)
      0:       return cnt0;
      1:       return cnt1;
      2:       return cnt2;
      default: return cnt3;
    endcase
  endfunction

  task automatic set_in(input int d, input logic v, input logic [7:0] b);
    case (d)
      0:       begin bus_b.tx_valid  = v; bus_b.tx_data  = b; end
      1:       begin bus_pe.tx_valid = v; bus_pe.tx_data = b; end
      2:       begin bus_po.tx_valid = v; bus_po.tx_data = b; end
      default: begin bus_s2.tx_valid = v; bus_s2.tx_data = b; end
    endcase
  endtask

  // Present a byte until accepted; also checks that a full FIFO never advertises ready.
  task automatic push_byte(input int d, input logic [7:0] b, inout int full_hits);
    int   n;
    logic acc;
    n = 0;
    set_in(d, 1'b1, b);
    do begin
      acc = ready_of(d);
      if (cnt_of(d) == CW'(16)) begin
        full_hits++;
        chk("ready_when_full", 32'(acc), 32'd0);
      end
      step(1);
      n++;
    end while (!acc && n < 2000);
    chk("push_accepted", 32'(acc), 32'd1);
    set_in(d, 1'b0, 8'h00);
  endtask

  // Wait for a start bit, decode the frame at bit centres and check every stop-bit cycle.
  task automatic recv(input int d, input int par_en, input logic exp_par, input int stops,
                      input logic check_idle, output logic [7:0] b, output int t0, output int waited);
    int n;
    n = 0;
    b = 8'h00;
    t0 = 0;
    while (line[d] !== 1'b0 && n < 1000) begin
      step(1);
      n++;
    end
    waited = n;
    chk("start_seen", 32'(n < 1000), 32'd1);
    if (n < 1000) begin
      t0 = cyc;
      chk("busy_in_frame", 32'(busy[d]), 32'd1);
      step(2);
      chk("start_mid", 32'(line[d]), 32'd0);
      for (int j = 0; j < 8; j++) begin
        step(CPB);
        b[j] = line[d];
      end
      if (par_en != 0) begin
        step(CPB);
        chk("parity_bit", 32'(line[d]), 32'(exp_par));
      end
      step(2);
      for (int c = 0; c < stops * int'(CPB); c++) begin
        chk("stop_high", 32'(line[d]), 32'd1);
        if (c < stops * int'(CPB) - 1) step(1);
      end
      if (check_idle) begin
        step(1);
        chk("busy_end", 32'(busy[d]), 32'd0);
        chk("idle_line", 32'(line[d]), 32'd1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         t0, tprev, waited, lows, full_hits, n;

    full_hits = 0;
    for (int d = 0; d < 4; d++) set_in(d, 1'b0, 8'h00);

    // Reset held for three edges
    rst = 1'b1;
    step(1);
    chk("rst_uart_tx", 32'(line), 32'hF);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_count", 32'(cnt0), 32'd0);
    chk("rst_ready", 32'(ready_of(0)), 32'd0);
    step(2);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) chk("ready_after_rst", 32'(ready_of(d)), 32'd1);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (line !== 4'hF) lows++;
    end
    chk("idle_line_100", 32'(lows), 32'd0);

    // Single byte 0xA5: start appears one edge after acceptance, 40-cycle frame
    push_byte(0, 8'hA5, full_hits);
    recv(0, 0, 1'b0, 1, 1'b1, b, t0, waited);
    chk("single_latency", 32'(waited), 32'd1);
    chk("single_data", 32'(b), 32'hA5);

    // Burst 0x00..0x13 through a 16-deep FIFO
    fork
      begin
        for (int i = 0; i < 20; i++) push_byte(0, 8'(i), full_hits);
      end
      begin
        tprev = 0;
        for (int k = 0; k < 20; k++) begin
          recv(0, 0, 1'b0, 1, (k == 19), b, t0, waited);
          chk("burst_data", 32'(b), 32'(k));
          if (k > 0) chk("burst_spacing", 32'(t0 - tprev), 32'd40);
          tprev = t0;
        end
      end
    join
    chk("burst_hit_full", 32'(full_hits > 0), 32'd1);
    chk("burst_drained", 32'(cnt0), 32'd0);

    // Parity on 0x07: even -> 1, odd -> 0; 44-cycle frames
    push_byte(1, 8'h07, full_hits);
    recv(1, 1, 1'b1, 1, 1'b1, b, t0, waited);
    chk("even_par_data", 32'(b), 32'h07);
    push_byte(2, 8'h07, full_hits);
    recv(2, 1, 1'b0, 1, 1'b1, b, t0, waited);
    chk("odd_par_data", 32'(b), 32'h07);

    // Two stop bits between 0xFF and 0x00
    push_byte(3, 8'hFF, full_hits);
    push_byte(3, 8'h00, full_hits);
    recv(3, 0, 1'b0, 2, 1'b0, b, tprev, waited);
    chk("stop2_first", 32'(b), 32'hFF);
    recv(3, 0, 1'b0, 2, 1'b1, b, t0, waited);
    chk("stop2_second", 32'(b), 32'h00);
    chk("stop2_spacing", 32'(t0 - tprev), 32'd44);

    // Reset during data bit 3 of 0x55 with three bytes queued
    push_byte(0, 8'h55, full_hits);
    push_byte(0, 8'h11, full_hits);
    push_byte(0, 8'h22, full_hits);
    push_byte(0, 8'h33, full_hits);
    n = 0;
    while (line[0] !== 1'b0 && n < 100) begin
      step(1);
      n++;
    end
    chk("midrst_start", 32'(n < 100), 32'd1);
    step(18);
    chk("midrst_queued", 32'(cnt0), 32'd3);
    chk("midrst_busy_before", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    step(1);
    chk("midrst_line", 32'(line[0]), 32'd1);
    chk("midrst_count", 32'(cnt0), 32'd0);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_ready", 32'(ready_of(0)), 32'd0);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (line[0] !== 1'b1) lows++;
    end
    chk("midrst_silent", 32'(lows), 32'd0);
    chk("midrst_idle_busy", 32'(busy[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
